// File: rtl/ball_seq_ctrl_if.sv
// Ball datapath link: border-collision levels in, centring and
// direction commands out.
interface ball_seq_ctrl_if;
  logic horiz_collide;
  logic vert_collide;
  logic ball_reset;
  logic ball_up;
  logic ball_down;
  logic ball_left;
  logic ball_right;

  modport master (
    input  horiz_collide,
    input  vert_collide,
    output ball_reset,
    output ball_up,
    output ball_down,
    output ball_left,
    output ball_right
  );

  modport slave (
    output horiz_collide,
    output vert_collide,
    input  ball_reset,
    input  ball_up,
    input  ball_down,
    input  ball_left,
    input  ball_right
  );
endinterface

// File: rtl/ball_seq_ctrl.sv
// Game sequencer: button sync/debounce, frame ticks, hit detection
// and the IDLE/SERVE/PLAY/HIT/OVER state machine.
module ball_seq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SERVE_FRAMES    = 60,
  parameter int HIT_FRAMES      = 30,
  parameter int LIVES           = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vsync,
  input  logic            up,
  input  logic            down,
  input  logic            left,
  input  logic            right,
  ball_seq_ctrl_if.master bif,
  output logic [2:0]      state,
  output logic [1:0]      lives
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] SF = 8'(SERVE_FRAMES);
  localparam logic [7:0] HF = 8'(HIT_FRAMES);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    HIT   = 3'd3,
    OVER  = 3'd4
  } state_t;

  // button bits: [3]=up [2]=down [1]=left [0]=right
  logic [3:0]    btn_s1_q, btn_s2_q;
  logic [3:0]    db_q, db_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic          vs_s1_q, vs_s2_q, vs_s3_q;
  logic          col_q;
  logic          press_q, press_d;
  logic          tick_q, tick_d;
  logic          hit_q, hit_d;
  state_t        state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [7:0]    fc_q, fc_d, fc_inc;
  logic          brst_q, brst_d;
  logic [3:0]    dir_q, dir_d;
  logic          col;

  assign col = bif.horiz_collide | bif.vert_collide;

  // Counter runs only while the synced level disagrees with db.
  always_comb begin
    db_d  = db_q;
    cnt_d = '{default: '0};
    for (int i = 0; i < 4; i++) begin
      if (btn_s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i] = btn_s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    press_d = |(db_d & ~db_q);
    tick_d  = vs_s2_q & ~vs_s3_q;
    hit_d   = col & ~col_q;
  end

  assign fc_inc = (fc_q == 8'hFF) ? 8'hFF : fc_q + 8'd1;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    fc_d    = fc_q;
    unique case (state_q)
      IDLE: begin
        if (press_q) begin
          state_d = SERVE;
          lives_d = LIVES_INIT;
          fc_d    = '0;
        end
      end
      SERVE: begin
        if (tick_q) begin
          if (fc_inc >= SF) begin
            state_d = PLAY;
            fc_d    = '0;
          end else begin
            fc_d = fc_inc;
          end
        end
      end
      PLAY: begin
        if (hit_q) begin
          state_d = HIT;
          lives_d = lives_q - 2'd1;
          fc_d    = '0;
        end
      end
      HIT: begin
        if (tick_q) begin
          if (fc_inc >= HF) begin
            state_d = (lives_q != 2'd0) ? SERVE : OVER;
            fc_d    = '0;
          end else begin
            fc_d = fc_inc;
          end
        end
      end
      OVER: begin
        lives_d = '0;
        if (press_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        lives_d = '0;
        fc_d    = '0;
      end
    endcase
  end

  // Outputs decode the next state so they line up with state_q.
  always_comb begin
    dir_d  = '0;
    brst_d = !(state_d == PLAY || state_d == HIT);
    if (state_d == PLAY) begin
      dir_d[3] = db_q[3] & ~db_q[2];
      dir_d[2] = db_q[2] & ~db_q[3];
      dir_d[1] = db_q[1] & ~db_q[0];
      dir_d[0] = db_q[0] & ~db_q[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      db_q     <= '0;
      cnt_q    <= '{default: '0};
      vs_s1_q  <= 1'b0;
      vs_s2_q  <= 1'b0;
      vs_s3_q  <= 1'b0;
      col_q    <= 1'b0;
      press_q  <= 1'b0;
      tick_q   <= 1'b0;
      hit_q    <= 1'b0;
      state_q  <= IDLE;
      lives_q  <= '0;
      fc_q     <= '0;
      brst_q   <= 1'b1;
      dir_q    <= '0;
    end else begin
      btn_s1_q <= {up, down, left, right};
      btn_s2_q <= btn_s1_q;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      vs_s1_q  <= vsync;
      vs_s2_q  <= vs_s1_q;
      vs_s3_q  <= vs_s2_q;
      col_q    <= col;
      press_q  <= press_d;
      tick_q   <= tick_d;
      hit_q    <= hit_d;
      state_q  <= state_d;
      lives_q  <= lives_d;
      fc_q     <= fc_d;
      brst_q   <= brst_d;
      dir_q    <= dir_d;
    end
  end

  assign state          = state_q;
  assign lives          = lives_q;
  assign bif.ball_reset = brst_q;
  assign bif.ball_up    = dir_q[3];
  assign bif.ball_down  = dir_q[2];
  assign bif.ball_left  = dir_q[1];
  assign bif.ball_right = dir_q[0];

endmodule
